// File: rtl/add_arbiter_pkg.sv
// Shared constants and FSM encoding for the round-robin add arbiter.
package add_arbiter_pkg;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int OP_W            = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/add_arbiter_add32.sv
// Shared 32-bit unsigned adder with carry-out.
module add32
  import add_arbiter_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic [OP_W-1:0] sum,
  output logic            cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/add_arbiter_rr_pick.sv
// Round-robin pick: first requester at or after ptr (wrapping) wins; one-hot out.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// NUM_REQ requesters share one 32-bit adder; one-cycle registered result.
// Optional ADD_ARBITER_FIXED_PRIO0_EN: requester 0 always wins, others round-robin.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int ID_W    = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*OP_W-1:0] req_opA,
  input  logic [NUM_REQ*OP_W-1:0] req_opB,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [OP_W-1:0]         rsp_result,
  output logic                    rsp_overflow,
  output logic                    busy
);

  state_e state, state_nxt;
  logic [ID_W-1:0] ptr;

  logic [NUM_REQ-1:0][OP_W-1:0] opa_arr, opb_arr;
  logic [NUM_REQ-1:0] rr_req, rr_gnt, pick, gnt;
  logic [ID_W-1:0]    gnt_id, ptr_nxt;
  logic [OP_W-1:0]    mux_a, mux_b, sum;
  logic               cout, load, any_gnt, ptr_upd;

  assign opa_arr = req_opA;
  assign opb_arr = req_opB;

`ifdef ADD_ARBITER_FIXED_PRIO0_EN
  assign rr_req  = req_valid & ~NUM_REQ'(1);
  assign pick    = req_valid[0] ? NUM_REQ'(1) : rr_gnt;
  assign ptr_upd = any_gnt && (gnt_id != '0);
`else
  assign rr_req  = req_valid;
  assign pick    = rr_gnt;
  assign ptr_upd = any_gnt;
`endif

  rr_pick #(.N(NUM_REQ), .IDW(ID_W)) u_pick (
    .req (rr_req),
    .ptr (ptr),
    .gnt (rr_gnt)
  );

  // Grant only when the output register can take a new result, never in reset.
  assign load      = (state == EMPTY) || rsp_ready;
  assign gnt       = (load && reset_n) ? pick : '0;
  assign any_gnt   = |gnt;
  assign req_ready = gnt;

  always_comb begin
    mux_a  = '0;
    mux_b  = '0;
    gnt_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mux_a  = mux_a | opa_arr[i];
        mux_b  = mux_b | opb_arr[i];
        gnt_id = gnt_id | ID_W'(i);
      end
    end
  end

  assign ptr_nxt = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

  add32 u_add (
    .a    (mux_a),
    .b    (mux_b),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (any_gnt) state_nxt = FULL;
      FULL:    if (rsp_ready && !any_gnt) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= EMPTY;
      ptr          <= '0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ptr_upd) ptr <= ptr_nxt;
      if (any_gnt) begin
        rsp_id       <= gnt_id;
        rsp_result   <= sum;
        rsp_overflow <= cout;
      end
    end
  end

  assign rsp_valid = (state == FULL);
  assign busy      = rsp_valid || (|req_valid);

endmodule

// File: tb/tb_add_arbiter.sv
// Scoreboard bench for add_arbiter: model grants push expected results, DUT responses pop them.
module tb_add_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  logic            clock, reset_n, rsp_ready;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*32-1:0] req_opA, req_opB;
  logic            rsp_valid, rsp_overflow, busy;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_result;

  logic [31:0] opa [N];
  logic [31:0] opb [N];
  assign req_opA = {opa[3], opa[2], opa[1], opa[0]};
  assign req_opB = {opb[3], opb[2], opb[1], opb[0]};

  exp_t       q[$];
  logic [1:0] gid_log[$];
  logic [1:0] mptr;
  int         checks, errors;

  add_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_opA      (req_opA),
    .req_opB      (req_opB),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [N-1:0] model_pick(input logic [N-1:0] v, input logic [1:0] p);
    logic [N-1:0] g;
    g = '0;
`ifdef ADD_ARBITER_FIXED_PRIO0_EN
    if (v[0]) return 4'b0001;
    v[0] = 1'b0;
`endif
    for (int k = 0; k < N; k++) begin
      if (g == '0 && v[(int'(p) + k) % N]) g[(int'(p) + k) % N] = 1'b1;
    end
    return g;
  endfunction

  // One cycle: entered at negedge with inputs set; checks, updates model, returns at next negedge.
  task automatic tick();
    logic [N-1:0] eg;
    exp_t e;
    int id;
    #1;
    eg = (reset_n && (q.size() == 0 || rsp_ready)) ? model_pick(req_valid, mptr) : '0;
    checks++;
    if (req_ready !== eg) begin
      errors++;
      $display("FAIL req_ready got %b exp %b", req_ready, eg);
    end
    checks++;
    if (rsp_valid !== (q.size() != 0)) begin
      errors++;
      $display("FAIL rsp_valid got %b exp %b", rsp_valid, q.size() != 0);
    end
    if (q.size() != 0) begin
      checks++;
      if ({rsp_id, rsp_result, rsp_overflow} !== q[0]) begin
        errors++;
        $display("FAIL rsp got id=%0d res=%h ovf=%b exp id=%0d res=%h ovf=%b",
                 rsp_id, rsp_result, rsp_overflow, q[0].id, q[0].res, q[0].ovf);
      end
    end
    checks++;
    if (busy !== ((q.size() != 0) || (|req_valid))) begin
      errors++;
      $display("FAIL busy got %b", busy);
    end
    if (!reset_n) begin
      q.delete();
      mptr = 2'd0;
    end else begin
      if (q.size() != 0 && rsp_ready) void'(q.pop_front());
      if (eg != '0) begin
        id = 0;
        for (int i = 0; i < N; i++) if (eg[i]) id = i;
        e.id = 2'(id);
        {e.ovf, e.res} = {1'b0, opa[id]} + {1'b0, opb[id]};
        q.push_back(e);
        gid_log.push_back(2'(id));
`ifdef ADD_ARBITER_FIXED_PRIO0_EN
        if (id != 0) mptr = 2'((id + 1) % N);
`else
        mptr = 2'((id + 1) % N);
`endif
      end
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 ||
        rsp_result !== 32'd0 || rsp_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b v=%b id=%0d res=%h ovf=%b exp all zero",
               req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow);
    end
    @(negedge clock);
    tick();
    req_valid = '0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    rsp_ready = 1'b1;
    opa[0] = 32'd5;
    opb[0] = 32'd7;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'd12 || rsp_overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_add got v=%b id=%0d res=%0d ovf=%b exp v=1 id=0 res=12 ovf=0",
               rsp_valid, rsp_id, rsp_result, rsp_overflow);
    end
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [8];
    do_reset();
    gid_log.delete();
    for (int i = 0; i < N; i++) begin
      opa[i] = 32'h100 * (i + 1);
      opb[i] = 32'd3 + i;
    end
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    repeat (8) tick();
    req_valid = '0;
    tick();
    for (int i = 0; i < 8; i++) begin
`ifdef ADD_ARBITER_FIXED_PRIO0_EN
      exp_seq[i] = 2'd0;
`else
      exp_seq[i] = 2'(i % N);
`endif
    end
    checks++;
    if (gid_log.size() != 8) begin
      errors++;
      $display("FAIL rr_count got %0d exp 8", gid_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (gid_log[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL rr_seq[%0d] got %0d exp %0d", i, gid_log[i], exp_seq[i]);
        end
      end
    end
    tick();
  endtask

  task automatic test_overflow();
    rsp_ready = 1'b1;
    opa[2] = 32'hFFFF_FFFF;
    opb[2] = 32'h0000_0002;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (rsp_result !== 32'h0000_0001 || rsp_overflow !== 1'b1 || rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL overflow got id=%0d res=%h ovf=%b exp id=2 res=00000001 ovf=1",
               rsp_id, rsp_result, rsp_overflow);
    end
    tick();
    tick();
  endtask

  task automatic test_stall();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    tick();
    rsp_ready = 1'b0;
    repeat (3) tick();
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready === 4'b0000) begin
      errors++;
      $display("FAIL stall_release got req_ready=%b exp a grant", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid got v=%b res=%h rdy=%b exp v=0 res=0 rdy=0001",
               rsp_valid, rsp_result, req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        // Operands only change while not requesting; a pending request may be withdrawn.
        if (!req_valid[i]) begin
          opa[i] = $urandom;
          opb[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - opa[i] + 1 : $urandom;
          req_valid[i] = ($urandom_range(0, 1) == 1);
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    mptr      = 2'd0;
    reset_n   = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    @(negedge clock);
    @(negedge clock);
    test_reset();
    test_basic();
    test_round_robin();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one 32-bit adder (legal range 2..8).
REQ-002 The block SHALL have parameter ID_W, default 2, meaning the requester-index width, equal to clog2(NUM_REQ).
REQ-003 The block SHALL have port clock  in  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n  in  1  meaning the synchronous, active-low reset.
REQ-005 The block SHALL have port req_valid  in  NUM_REQ  meaning one request bit per requester.
REQ-006 The block SHALL have port req_opA  in  NUM_REQ*32  meaning packed operand A; requester i uses bits [32i+31:32i].
REQ-007 The block SHALL have port req_opB  in  NUM_REQ*32  meaning packed operand B, packed the same way as req_opA.
REQ-008 The block SHALL have port req_ready  out  NUM_REQ  meaning a one-hot grant, combinational in the same cycle.
REQ-009 The block SHALL have port rsp_valid  out  1  meaning a registered result is present.
REQ-010 The block SHALL have port rsp_ready  in  1  meaning the consumer accepts the result.
REQ-011 The block SHALL have port rsp_id  out  ID_W  meaning the index of the requester that owns the result.
REQ-012 The block SHALL have port rsp_result  out  32  meaning the sum opA+opB, modulo 2^32.
REQ-013 The block SHALL have port rsp_overflow  out  1  meaning the adder carry-out from bit 31.
REQ-014 The block SHALL have port busy  out  1  meaning rsp_valid is high or any req_valid bit is high.

Function
REQ-015 A transfer SHALL occur for requester i when req_valid[i] and req_ready[i] are both high; req_ready SHALL be at most one-hot.
REQ-016 Grants SHALL be issued only when the output register can load: rsp_valid==0, or rsp_valid==1 with rsp_ready==1 in the same cycle.
REQ-017 The output register SHALL hold state when rsp_valid==1 and rsp_ready==0; req_ready SHALL then be all zeros and no grant SHALL be issued.
REQ-018 Latency SHALL be one cycle: a grant in cycle N presents rsp_valid, rsp_id, rsp_result and rsp_overflow in cycle N+1.
REQ-019 Sustained throughput SHALL be one add per cycle while rsp_ready stays high.
REQ-020 Output control SHALL be a two-state FSM: EMPTY goes to FULL on a grant; FULL stays FULL on accept-with-new-grant; FULL goes to EMPTY on accept-without-grant; FULL holds when stalled.
REQ-021 Arbitration SHALL be round-robin: after granting requester i, the highest priority SHALL pass to (i+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
REQ-022 The priority pointer SHALL update only on a grant.
REQ-023 While req_valid[i] is high and not yet granted, requester i SHALL hold its operands stable; deasserting req_valid before grant SHALL be legal and withdraws the request.
REQ-024 With all NUM_REQ requesters continuously requesting, every requester SHALL be granted within NUM_REQ consecutive grants.
REQ-025 Arithmetic SHALL be unsigned 32-bit addition; the result SHALL wrap and the carry SHALL appear on rsp_overflow.

Reset
REQ-026 While reset_n==0 at a clock edge, rsp_valid, rsp_id, rsp_result and rsp_overflow SHALL clear to 0, the FSM SHALL go to EMPTY and the pointer SHALL reset to 0.
REQ-027 req_ready SHALL be all zeros during reset.
REQ-028 Reset asserted mid-operation SHALL discard any held response, and no grant SHALL be issued in that cycle.

Configuration
REQ-029 With macro ADD_ARBITER_FIXED_PRIO0_EN defined, requester 0 SHALL win whenever it requests and SHALL not move the pointer; the other requesters SHALL round-robin among themselves.
REQ-030 Without ADD_ARBITER_FIXED_PRIO0_EN, all requesters SHALL use pure round-robin per REQ-021.

Structure
REQ-031 A shared package/include add_arbiter_pkg SHALL hold the default NUM_REQ, the FSM state encodings (EMPTY=0, FULL=1) and the operand width constant 32.
REQ-032 The round-robin pick SHALL be a sub-module rr_pick (inputs: request vector and pointer; output: one-hot grant).
REQ-033 The addition SHALL use the team's existing 32-bit add unit, instantiated once and fed by the operand mux.

Verification
REQ-034 After reset, drive req_valid=0001, opA=5, opB=7 -> req_ready=0001 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_overflow=0.
REQ-035 With all four requesting and rsp_ready=1 held for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3.
REQ-036 Present opA=FFFFFFFF, opB=00000002 -> rsp_result=00000001, rsp_overflow=1.
REQ-037 Hold rsp_ready=0 for 3 cycles with response held and req_valid=1111 -> req_ready=0000 and outputs stable; then raise rsp_ready -> accept and new grant in the same cycle.
REQ-038 Pull reset_n low while rsp_valid=1 -> next cycle rsp_valid=0, rsp_result=0, and the next grant goes to requester 0.
REQ-039 With ADD_ARBITER_FIXED_PRIO0_EN defined and req_valid=1111 held -> rsp_id sequence 0,0,0,... with requesters 1..3 never granted.
